// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the CPU memory stage and a
// DMA/loader port. The CPU has priority. The DMA port is forced to win once it
// has been denied for STARVE_LIMIT consecutive requesting cycles. Grants are
// combinational. Read responses and the out-of-range error pulse are
// registered, with a latency of one cycle.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (word address, store data)
//   cpu_gnt                  CPU access accepted this cycle
//   cpu_rvalid/rdata         CPU read response (one cycle after the grant)
//   dma_*                    same set of signals for the DMA/loader port
//   mem_we/addr/wd           drive the memory (writes on posedge)
//   mem_rd                   combinational memory read data for mem_addr
//   err                      one-cycle pulse after a granted out-of-range access
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,

  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,

  output logic        err
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             dma_wins;
  logic             any_gnt;
  logic             win_we;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic             in_range;
  logic [31:0]      rd_word;

  logic             cpu_rvalid_q;
  logic             dma_rvalid_q;
  logic [31:0]      cpu_rdata_q;
  logic [31:0]      dma_rdata_q;
  logic             err_q;

  // Arbitration and memory-side mux.
  // NOTE: every signal written here gets a value on every path, so no
  // latch is inferred. The muxes select the winner explicitly and default to 0.
  always_comb begin
    dma_wins  = dma_req && (!cpu_req || (starve_cnt == CNT_MAX));
    cpu_gnt   = !rst && cpu_req && !dma_wins;
    dma_gnt   = !rst && dma_wins;
    any_gnt   = cpu_gnt || dma_gnt;

    win_we    = dma_gnt ? dma_we    : cpu_we;
    win_addr  = dma_gnt ? dma_addr  : cpu_addr;
    win_wdata = dma_gnt ? dma_wdata : cpu_wdata;

    in_range  = (win_addr[31:ADDR_W] == '0);

    mem_we    = any_gnt && win_we && in_range;
    mem_addr  = any_gnt ? win_addr  : 32'd0;
    mem_wd    = any_gnt ? win_wdata : 32'd0;

    // An out-of-range read returns zero, not whatever the memory aliases to.
    rd_word   = in_range ? mem_rd : 32'd0;
  end

  // NOTE: state updates use non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      // Count denied DMA cycles. The counter saturates, so it cannot wrap
      // back to 0 while the DMA port is still waiting.
      if (dma_req && !dma_gnt) begin
        if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end

      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dma_rvalid_q <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata_q <= rd_word;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata_q <= rd_word;
      end

      err_q <= any_gnt && !in_range;
    end
  end

  // Responses are masked while reset is asserted. A read granted just before
  // reset therefore never shows a response during the reset cycle.
  assign cpu_rvalid = cpu_rvalid_q && !rst;
  assign dma_rvalid = dma_rvalid_q && !rst;
  assign cpu_rdata  = rst ? 32'd0 : cpu_rdata_q;
  assign dma_rdata  = rst ? 32'd0 : dma_rdata_q;
  assign err        = err_q && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. It provides a behavioural data memory
// and a reference model of the arbiter, which holds a starvation counter as an
// integer and a word array for the memory contents. It applies a table of
// directed vectors, a reset-during-response sequence, and randomized
// requester traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we, err;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  // Physical memory seen by the DUT: combinational read, posedge write.
  logic [31:0] mem [DEPTH];
  assign mem_rd = mem[mem_addr[ADDR_W-1:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[ADDR_W-1:0]] <= mem_wd;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err(err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          starve;
  logic [31:0] ref_mem [DEPTH];
  logic        m_crv, m_drv, m_err;
  logic [31:0] m_crd, m_drd;
  logic        e_cg, e_dg;
  logic [31:0] e_addr, e_wd;
  logic        e_we;

  function automatic bit in_rng(input logic [31:0] a);
    return a < DEPTH;
  endfunction

  task automatic drive(input logic r,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic settle_check();
    #1;
    e_dg = !rst && dma_req && (!cpu_req || starve >= LIMIT);
    e_cg = !rst && cpu_req && !e_dg;
    e_addr = 32'd0; e_wd = 32'd0; e_we = 1'b0;
    if (e_cg) begin e_addr = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we && in_rng(cpu_addr); end
    if (e_dg) begin e_addr = dma_addr; e_wd = dma_wdata; e_we = dma_we && in_rng(dma_addr); end
    check("cpu_gnt",    cpu_gnt,    e_cg);
    check("dma_gnt",    dma_gnt,    e_dg);
    check("mem_we",     mem_we,     e_we);
    check("mem_addr",   mem_addr,   e_addr);
    check("mem_wd",     mem_wd,     e_wd);
    check("cpu_rvalid", cpu_rvalid, m_crv && !rst);
    check("dma_rvalid", dma_rvalid, m_drv && !rst);
    check("cpu_rdata",  cpu_rdata,  rst ? 32'd0 : m_crd);
    check("dma_rdata",  dma_rdata,  rst ? 32'd0 : m_drd);
    check("err",        err,        m_err && !rst);
  endtask

  // Clock edge: advance the model, then return at the following negedge.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      starve = 0; m_crv = 0; m_drv = 0; m_err = 0; m_crd = 0; m_drd = 0;
    end else begin
      if (dma_req && !e_dg) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      else starve = 0;
      m_crv = e_cg && !cpu_we;
      m_drv = e_dg && !dma_we;
      if (m_crv) m_crd = in_rng(cpu_addr) ? ref_mem[cpu_addr[ADDR_W-1:0]] : 32'd0;
      if (m_drv) m_drd = in_rng(dma_addr) ? ref_mem[dma_addr[ADDR_W-1:0]] : 32'd0;
      m_err = (e_cg || e_dg) && !in_rng(e_addr);
      if (e_cg && cpu_we && in_rng(cpu_addr)) ref_mem[cpu_addr[ADDR_W-1:0]] = cpu_wdata;
      if (e_dg && dma_we && in_rng(dma_addr)) ref_mem[dma_addr[ADDR_W-1:0]] = dma_wdata;
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cr, cw; logic [31:0] ca, cd;
    logic        dr, dw; logic [31:0] da, dd;
    logic        cg, dg, mwe;      // this cycle
    logic        crv, drv, er;     // next cycle
    logic [31:0] rdat;             // next-cycle read data on the responding port
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input logic cg, input logic dg, input logic mwe,
                              input logic crv, input logic drv, input logic er, input logic [31:0] rdat);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.cg = cg; v.dg = dg; v.mwe = mwe;
    v.crv = crv; v.drv = drv; v.er = er; v.rdat = rdat;
    return v;
  endfunction

  logic        c_pend, c_we_r, d_pend, d_we_r;
  logic [31:0] c_addr_r, c_wd_r, d_addr_r, d_wd_r;

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0400;
    return 32'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    starve = 0; m_crv = 0; m_drv = 0; m_err = 0; m_crd = 0; m_drd = 0;

    // Reset: gnt and mem_we stay 0 even with requests pending.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55);
      settle_check();
      advance();
    end

    // Directed table.
    vecs.push_back(mk(1,1,32'h28,32'h2,        0,0,0,0, 1,0,1, 0,0,0, 0));
    vecs.push_back(mk(1,0,32'h28,0,            0,0,0,0, 1,0,0, 1,0,0, 32'h2));
    vecs.push_back(mk(1,1,32'h0,32'h11111111,  0,0,0,0, 1,0,1, 0,0,0, 0));
    vecs.push_back(mk(1,1,32'h1,32'hA1,        0,0,0,0, 1,0,1, 0,0,0, 0));
    vecs.push_back(mk(1,1,32'h2,32'hA2,        0,0,0,0, 1,0,1, 0,0,0, 0));
    vecs.push_back(mk(1,1,32'h3,32'hA3,        0,0,0,0, 1,0,1, 0,0,0, 0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h400,32'hDEADBEEF, 0,1,0, 0,0,1, 0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h0,0,              0,1,0, 0,1,0, 32'h11111111));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h500,0,            0,1,0, 0,1,1, 32'h0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h0,0, 0,1,0, 0,1,0, 32'h11111111));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h1,0, 0,1,0, 0,1,0, 32'hA1));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h2,0, 0,1,0, 0,1,0, 32'hA2));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h3,0, 0,1,0, 0,1,0, 32'hA3));
    // Both ports reading continuously: four CPU grants, then one DMA grant.
    for (int k = 0; k < 10; k++) begin
      logic cw_win;
      cw_win = (k % 5) != 4;
      vecs.push_back(mk(1,0,32'h28,0, 1,0,32'h1,0, cw_win,!cw_win,0, cw_win,!cw_win,0,
                        cw_win ? 32'h2 : 32'hA1));
    end
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0));

    foreach (vecs[i]) begin
      drive(0, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
               vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      settle_check();
      check($sformatf("vec%0d cpu_gnt", i), cpu_gnt, vecs[i].cg);
      check($sformatf("vec%0d dma_gnt", i), dma_gnt, vecs[i].dg);
      check($sformatf("vec%0d mem_we", i),  mem_we,  vecs[i].mwe);
      advance();
      #1;
      check($sformatf("vec%0d cpu_rvalid", i), cpu_rvalid, vecs[i].crv);
      check($sformatf("vec%0d dma_rvalid", i), dma_rvalid, vecs[i].drv);
      check($sformatf("vec%0d err", i),        err,        vecs[i].er);
      if (vecs[i].crv) check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].rdat);
      if (vecs[i].drv) check($sformatf("vec%0d dma_rdata", i), dma_rdata, vecs[i].rdat);
    end

    // Read granted, then reset asserted the next cycle: no response appears.
    drive(0, 1, 0, 32'h28, 0, 0, 0, 0, 0);
    settle_check();
    check("rst_seq gnt", cpu_gnt, 1'b1);
    advance();
    drive(1, 1, 0, 32'h28, 0, 0, 0, 0, 0);
    settle_check();
    check("rst_seq rvalid in reset", cpu_rvalid, 1'b0);
    check("rst_seq gnt in reset",    cpu_gnt,    1'b0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle_check();
    check("rst_seq rvalid after", cpu_rvalid, 1'b0);
    check("rst_seq rdata after",  cpu_rdata,  32'd0);
    check("rst_seq err after",    err,        1'b0);
    advance();
    settle_check();

    // Randomized traffic. Each requester holds its request until granted.
    c_pend = 0; d_pend = 0;
    c_we_r = 0; c_addr_r = 0; c_wd_r = 0; d_we_r = 0; d_addr_r = 0; d_wd_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1; c_we_r = 1'($urandom_range(0, 1)); c_addr_r = rand_addr(); c_wd_r = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_we_r = 1'($urandom_range(0, 1)); d_addr_r = rand_addr(); d_wd_r = $urandom;
      end
      drive(0, c_pend, c_we_r, c_addr_r, c_wd_r, d_pend, d_we_r, d_addr_r, d_wd_r);
      settle_check();
      if (e_cg) c_pend = 0;
      if (e_dg) d_pend = 0;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
